// File: rtl/trigger_capture_unit.sv
// Logic-analyzer trigger/capture stage: synchronizes probes, waits for a masked edge,
// then streams decimated samples into the sample FIFO. Define TRIGGER_SYNC3_EN for a 3-flop synchronizer.
module trigger_capture_unit #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_rst,
    input  logic [2:0] trig_mask,
    input  logic [2:0] trig_pol,
    input  logic [2:0] probe_in,
    input  logic       fifo_wrfull,
    output logic       fifo_wrreq,
    output logic [2:0] fifo_data,
    output logic       armed,
    output logic       triggered
);

`ifdef TRIGGER_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif
    localparam int CHAIN_W = 3 * SYNC_STAGES;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CHAIN_W-1:0]   sync_chain_q;
    logic [2:0]           prev_q;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 wrreq_q, wrreq_d;
    logic [2:0]           data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 trig_q, trig_d;

    logic [2:0] sync_val;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] sel_edge;
    logic       hit;
    logic       wrap;

    // Newest sample enters at the low end; the oldest stage is the synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
            prev_q       <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[CHAIN_W-4:0], probe_in};
            prev_q       <= sync_val;
        end
    end

    assign sync_val = sync_chain_q[CHAIN_W-1 -: 3];
    assign rise     = sync_val & ~prev_q;
    assign fall     = ~sync_val & prev_q;
    assign sel_edge = (trig_pol & rise) | (~trig_pol & fall);
    assign hit      = (trig_mask == 3'b000) || ((trig_mask & sel_edge) != 3'b000);
    assign wrap     = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        if (sync_rst) begin
            state_d = ST_DISABLED;
            div_d   = '0;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (hit) begin
                        state_d = ST_CAPTURE;
                        div_d   = '0;
                        wrreq_d = ~fifo_wrfull;
                        data_d  = sync_val;
                    end
                end
                ST_CAPTURE: begin
                    // A full FIFO ends the capture; a write due on this edge is dropped.
                    if (fifo_wrfull) begin
                        state_d = ST_DONE;
                        div_d   = '0;
                    end else begin
                        div_d = wrap ? '0 : div_q + DIV_WIDTH'(1);
                        if (wrap) begin
                            wrreq_d = 1'b1;
                            data_d  = sync_val;
                        end
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_DISABLED;
            endcase
        end
        armed_d = (state_d == ST_ARMED);
        trig_d  = (state_d == ST_CAPTURE) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            div_q   <= '0;
            wrreq_q <= 1'b0;
            data_q  <= 3'b000;
            armed_q <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            trig_q  <= trig_d;
        end
    end

    assign fifo_wrreq = wrreq_q;
    assign fifo_data  = data_q;
    assign armed      = armed_q;
    assign triggered  = trig_q;

endmodule

// File: tb/tb_trigger_capture_unit.sv
// Scoreboard bench for trigger_capture_unit: randomized probe scenarios, expected writes and
// armed/triggered levels derived from the trigger/decimation rules at transaction level.
module tb_trigger_capture_unit;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam int HMAX  = 16384;
`ifdef TRIGGER_SYNC3_EN
    localparam int S = 3;
`else
    localparam int S = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_rst = 1'b1;
    logic [2:0] trig_mask = 3'b000;
    logic [2:0] trig_pol = 3'b000;
    logic [2:0] probe_in = 3'b000;
    logic       fifo_wrfull;
    logic       fifo_wrreq;
    logic [2:0] fifo_data;
    logic       armed;
    logic       triggered;

    int edge_cnt = 0;
    int fifo_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit exp_vld [HMAX];
    bit exp_arm [HMAX];
    bit exp_trg [HMAX];

    typedef struct packed {
        int         edge_n;
        logic [2:0] data;
    } wr_t;
    wr_t sb_q[$];
    wr_t w_mon;

    trigger_capture_unit #(.SAMPLE_DIV(DIV), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_rst   (sync_rst),
        .trig_mask  (trig_mask),
        .trig_pol   (trig_pol),
        .probe_in   (probe_in),
        .fifo_wrfull(fifo_wrfull),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .armed      (armed),
        .triggered  (triggered)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Sample FIFO stand-in: the controller drains it while the block is held disabled.
    always @(posedge clk) begin
        if (sync_rst) fifo_cnt <= 0;
        else if (fifo_wrreq) fifo_cnt <= fifo_cnt + 1;
    end
    assign fifo_wrfull = (fifo_cnt >= DEPTH);

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic bit model_hit(input logic [2:0] s, input logic [2:0] q,
                                     input logic [2:0] mask, input logic [2:0] pol);
        if (mask == 3'b000) return 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            bit went_up, went_down, seen;
            went_up   = s[ch] && !q[ch];
            went_down = !s[ch] && q[ch];
            seen      = pol[ch] ? went_up : went_down;
            if (mask[ch] && seen) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (edge_cnt < HMAX && exp_vld[edge_cnt]) begin
                check("armed", armed, exp_arm[edge_cnt]);
                check("triggered", triggered, exp_trg[edge_cnt]);
            end
            if (fifo_wrreq) begin
                check("wrreq_while_full", fifo_wrfull, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_write_edge", edge_cnt, -1);
                end else begin
                    w_mon = sb_q.pop_front();
                    check("write_edge", edge_cnt, w_mon.edge_n);
                    check("write_data", fifo_data, w_mon.data);
                end
            end
        end
    end

    // kind 0: random probes; 1: random with a mid-run disable; 2/3: directed edge patterns.
    task automatic run_scn(input logic [2:0] mask, input logic [2:0] pol, input int kind);
        logic [2:0] pv[$];
        bit         sr[$];
        logic [2:0] cur;
        int         e0, n, i, r, x, t, l1;
        cur = 3'b000;
        for (int j = 0; j < 5; j++) begin
            if (kind < 2) cur = 3'($urandom);
            pv.push_back(cur);
            sr.push_back(1'b1);
        end
        l1 = (kind == 1) ? 12 + int'($urandom_range(0, 29)) : 100;
        for (int j = 0; j < l1; j++) begin
            case (kind)
                2: begin
                    if (j == 4) cur[0] = 1'b1;
                    if (j == 8) cur[0] = 1'b0;
                    if (j == 14) cur[1] = 1'b1;
                end
                3: begin
                    if (j == 4) cur[0] = 1'b1;
                    if (j == 12) cur[0] = 1'b0;
                end
                default: if ($urandom_range(0, 5) == 0) cur = cur ^ 3'($urandom_range(1, 7));
            endcase
            pv.push_back(cur);
            sr.push_back(1'b0);
        end
        if (kind == 1) begin
            for (int j = 0; j < 3; j++) begin pv.push_back(cur); sr.push_back(1'b1); end
            for (int j = 0; j < 100; j++) begin
                if ($urandom_range(0, 5) == 0) cur = cur ^ 3'($urandom_range(1, 7));
                pv.push_back(cur);
                sr.push_back(1'b0);
            end
        end
        for (int j = 0; j < 4; j++) begin pv.push_back(cur); sr.push_back(1'b1); end

        e0 = edge_cnt + 1;
        n  = pv.size();
        if (e0 + n >= HMAX) begin
            check("history_overflow", e0 + n, HMAX - 1);
            return;
        end
        for (int j = 0; j < n; j++) begin
            exp_vld[e0+j] = 1'b1;
            exp_arm[e0+j] = 1'b0;
            exp_trg[e0+j] = 1'b0;
        end
        i = 1;
        while (i < n) begin
            if (!sr[i] && sr[i-1]) begin
                r = i;
                x = r;
                while (x < n && !sr[x]) x++;
                t = -1;
                for (int e = r + 1; e < x && t < 0; e++)
                    if (model_hit(pv[e-S], pv[e-S-1], mask, pol)) t = e;
                for (int e = r; e < x; e++) begin
                    exp_arm[e0+e] = (t < 0) || (e < t);
                    exp_trg[e0+e] = (t >= 0) && (e >= t);
                end
                if (t >= 0)
                    for (int k = 0; k < DEPTH && t + k * DIV < x; k++)
                        sb_q.push_back('{edge_n: e0 + t + k * DIV, data: pv[t+k*DIV-S]});
                i = x;
            end else begin
                i++;
            end
        end

        trig_mask = mask;
        trig_pol  = pol;
        for (int j = 0; j < n; j++) begin
            probe_in = pv[j];
            sync_rst = sr[j];
            @(negedge clk);
        end
        check("writes_outstanding", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_wrreq", fifo_wrreq, 0);
        check("reset_data", fifo_data, 0);
        check("reset_armed", armed, 0);
        check("reset_triggered", triggered, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        run_scn(3'b010, 3'b010, 2);
        run_scn(3'b001, 3'b000, 3);
        run_scn(3'b000, 3'($urandom), 0);
        for (int s = 0; s < 8; s++)
            run_scn(3'($urandom), 3'($urandom), int'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a capture.
        chk_en    = 1'b0;
        trig_mask = 3'b000;
        probe_in  = 3'b111;
        sync_rst  = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_triggered", triggered, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wrreq", fifo_wrreq, 0);
        check("async_rst_data", fifo_data, 0);
        check("async_rst_armed", armed, 0);
        check("async_rst_triggered", triggered, 0);
        sync_rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_armed", armed, 0);
        sb_q.delete();
        chk_en = 1'b1;

        run_scn(3'($urandom), 3'($urandom), 0);
        run_scn(3'b000, 3'b000, 1);
        run_scn(3'($urandom), 3'($urandom), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
